// File: rtl/serpent_dec_core.sv
// Serpent-128 iterative decryption core: one inverse round per clock, 32 rounds per block.
// Subkeys are fetched externally through o_key_idx / i_subkey (same-cycle lookup).
module serpent_dec_core (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_data,
    output logic [5:0]   o_key_idx,
    input  logic [127:0] i_subkey,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_data,
    output logic         o_busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Inverse S-boxes 7..0; entry v of box k lives at InvSbox[k][4*v +: 4].
    localparam logic [7:0][63:0] InvSbox = {
        64'h241A7BC58FE9D603, 64'hB8C27E940635D1AF, 64'h0AC7356BED1492F8,
        64'h1DF46BC2E79A3805, 64'h1F842C53D6EB7A90, 64'h7A85D63021EB4F9C,
        64'h0AD1974B3C6FE285, 64'h289F74E1C56A0B3D
    };

    localparam logic [5:0] KeyIdxFinal = 6'd32;

    state_e       state_q, state_d;
    logic [127:0] x_q, x_d;
    logic [4:0]   r_q, r_d;
    logic         ready_q, ready_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic [5:0]   key_idx_q, key_idx_d;
    logic [127:0] lt_out;
    logic [127:0] round_out;

    function automatic logic [31:0] rotr(input logic [31:0] v, input int unsigned n);
        return (v >> n) | (v << (32 - n));
    endfunction

    // Inverse of the Serpent linear transform; words ordered {X0,X1,X2,X3}.
    function automatic logic [127:0] lt_inv(input logic [127:0] x);
        logic [31:0] x0, x1, x2, x3;
        x0 = x[127:96];
        x1 = x[95:64];
        x2 = x[63:32];
        x3 = x[31:0];
        x2 = rotr(x2, 22);
        x0 = rotr(x0, 5);
        x2 = x2 ^ x3 ^ (x1 << 7);
        x0 = x0 ^ x1 ^ x3;
        x3 = rotr(x3, 7);
        x1 = rotr(x1, 1);
        x3 = x3 ^ x2 ^ (x0 << 3);
        x1 = x1 ^ x0 ^ x2;
        x2 = rotr(x2, 3);
        x0 = rotr(x0, 13);
        return {x0, x1, x2, x3};
    endfunction

    // Bitsliced inverse S-box: column j forms nibble {X3[j],X2[j],X1[j],X0[j]}.
    function automatic logic [127:0] inv_sbox_layer(input logic [2:0] k, input logic [127:0] x);
        logic [31:0] w0, w1, w2, w3;
        logic [3:0]  nib;
        logic [3:0]  sub;
        w0 = x[127:96];
        w1 = x[95:64];
        w2 = x[63:32];
        w3 = x[31:0];
        for (int j = 0; j < 32; j++) begin
            nib   = {w3[j], w2[j], w1[j], w0[j]};
            sub   = InvSbox[k][{nib, 2'b00} +: 4];
            w0[j] = sub[0];
            w1[j] = sub[1];
            w2[j] = sub[2];
            w3[j] = sub[3];
        end
        return {w0, w1, w2, w3};
    endfunction

    // One inverse round: the first round (r==31) has no LT to undo.
    always_comb begin
        lt_out    = lt_inv(x_q);
        round_out = inv_sbox_layer(r_q[2:0], (r_q == 5'd31) ? x_q : lt_out) ^ i_subkey;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        r_d     = r_q;
        unique case (state_q)
            StIdle: begin
                // ready_q gates acceptance so nothing is taken in the cycle after reset release
                if (i_valid && ready_q) begin
                    x_d     = i_data ^ i_subkey;
                    r_d     = 5'd31;
                    state_d = StRun;
                end
            end
            StRun: begin
                x_d = round_out;
                if (r_q == 5'd0) begin
                    state_d = StDone;
                end else begin
                    r_d = r_q - 5'd1;
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        ready_d   = (state_d == StIdle);
        valid_d   = (state_d == StDone);
        busy_d    = (state_d != StIdle);
        key_idx_d = (state_d == StRun) ? {1'b0, r_d} : KeyIdxFinal;
    end

    // State and output registers; reset aborts any block in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            x_q       <= '0;
            r_q       <= '0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            key_idx_q <= KeyIdxFinal;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            r_q       <= r_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            key_idx_q <= key_idx_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = valid_q;
    assign o_busy    = busy_q;
    assign o_key_idx = key_idx_q;
    assign o_data    = valid_q ? x_q : '0;

endmodule

// File: tb/tb_serpent_dec_core.sv
// Bench for serpent_dec_core: a forward Serpent model encrypts, the DUT must recover the plaintext.
module tb_serpent_dec_core;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [127:0] i_data;
    logic [5:0]   o_key_idx;
    logic [127:0] i_subkey;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_data;
    logic         o_busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [127:0] sk [33];
    bit           sk_garbage;

    int unsigned sbox [8][16] = '{
        '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
        '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
        '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
        '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
        '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
        '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
        '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
        '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
    };

    serpent_dec_core u_dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .o_key_idx (o_key_idx),
        .i_subkey  (i_subkey),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Subkey memory answering the DUT's same-cycle lookup.
    always_comb begin
        if (sk_garbage) begin
            i_subkey = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
        end else if (o_key_idx <= 6'd32) begin
            i_subkey = sk[o_key_idx];
        end else begin
            i_subkey = '0;
        end
    end

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] sbox_layer(input int k, input logic [127:0] x);
        logic [31:0] a, b, c, d;
        logic [3:0]  nib;
        logic [3:0]  o;
        a = x[127:96];
        b = x[95:64];
        c = x[63:32];
        d = x[31:0];
        for (int j = 0; j < 32; j++) begin
            nib  = {d[j], c[j], b[j], a[j]};
            o    = 4'(sbox[k][nib]);
            a[j] = o[0];
            b[j] = o[1];
            c[j] = o[2];
            d[j] = o[3];
        end
        return {a, b, c, d};
    endfunction

    function automatic logic [127:0] lt(input logic [127:0] x);
        logic [31:0] a, b, c, d;
        a = x[127:96];
        b = x[95:64];
        c = x[63:32];
        d = x[31:0];
        a = rotl(a, 13);
        c = rotl(c, 3);
        b = b ^ a ^ c;
        d = d ^ c ^ (a << 3);
        b = rotl(b, 1);
        d = rotl(d, 7);
        a = a ^ b ^ d;
        c = c ^ d ^ (b << 7);
        a = rotl(a, 5);
        c = rotl(c, 22);
        return {a, b, c, d};
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] x;
        x = pt;
        for (int i = 0; i < 32; i++) begin
            x = sbox_layer(i % 8, x ^ sk[i]);
            if (i < 31) x = lt(x);
            else x = x ^ sk[32];
        end
        return x;
    endfunction

    task automatic key_schedule(input logic [255:0] key);
        logic [31:0] w [140];
        for (int i = 0; i < 8; i++) w[i] = key[32*i +: 32];
        for (int i = 0; i < 132; i++) begin
            w[i+8] = rotl(w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ 32'h9e3779b9 ^ 32'(i), 11);
        end
        for (int n = 0; n < 33; n++) begin
            sk[n] = sbox_layer((35 - n) % 8, {w[8+4*n], w[9+4*n], w[10+4*n], w[11+4*n]});
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rnd256();
        return {rnd128(), rnd128()};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Offers one block, returns its result and the accept-to-valid edge count (40 = timeout).
    task automatic send_and_wait(input logic [127:0] ct, output logic [127:0] got,
                                 output int lat);
        int n;
        n = 0;
        while (!o_ready && n < 100) begin
            tick();
            n++;
        end
        i_data  = ct;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_data  = rnd128();
        lat = 0;
        while (!o_valid && lat < 40) begin
            tick();
            lat++;
        end
        got = o_data;
        if (i_ready) tick();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_ready: got %b expected 0", o_ready);
        end
        checks++;
        if (o_key_idx !== 6'd32) begin
            failures++;
            $display("FAIL rst_key_idx: got %0d expected 32", o_key_idx);
        end
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_data !== 128'h0) begin
            failures++;
            $display("FAIL rst_outputs: valid=%b busy=%b data=%h expected 0/0/0",
                     o_valid, o_busy, o_data);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_release_ready: got %b expected 0 before first edge", o_ready);
        end
        tick();
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_ready_rise: got %b expected 1", o_ready);
        end
    endtask

    task automatic test_kat();
        logic [127:0] got;
        int lat;
        key_schedule(256'h0);
        send_and_wait(encrypt(128'h0), got, lat);
        checks++;
        if (got !== 128'h0) begin
            failures++;
            $display("FAIL kat_data: got %h expected 0", got);
        end
        checks++;
        if (lat !== 32) begin
            failures++;
            $display("FAIL kat_latency: got %0d expected 32", lat);
        end
    endtask

    task automatic test_timing();
        logic [127:0] pt;
        int n;
        key_schedule(rnd256());
        pt = rnd128();
        n  = 0;
        while (!o_ready && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (o_key_idx !== 6'd32) begin
            failures++;
            $display("FAIL timing_idle_idx: got %0d expected 32", o_key_idx);
        end
        i_data  = encrypt(pt);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_data  = rnd128();
        for (int c = 0; c < 32; c++) begin
            checks++;
            if (o_key_idx !== 6'(31 - c) || o_valid !== 1'b0 || o_busy !== 1'b1 ||
                o_ready !== 1'b0 || o_data !== 128'h0) begin
                failures++;
                $display("FAIL timing_run[%0d]: idx=%0d valid=%b busy=%b ready=%b data=%h expected %0d/0/1/0/0",
                         c, o_key_idx, o_valid, o_busy, o_ready, o_data, 31 - c);
            end
            tick();
        end
        checks++;
        if (o_valid !== 1'b1 || o_data !== pt) begin
            failures++;
            $display("FAIL timing_done: valid=%b data=%h expected 1/%h", o_valid, o_data, pt);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1 || o_data !== 128'h0) begin
            failures++;
            $display("FAIL timing_handoff: valid=%b busy=%b ready=%b data=%h expected 0/0/1/0",
                     o_valid, o_busy, o_ready, o_data);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] pt, got;
        int lat;
        key_schedule(rnd256());
        pt      = rnd128();
        i_ready = 1'b0;
        send_and_wait(encrypt(pt), got, lat);
        sk_garbage = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== pt || o_ready !== 1'b0 || o_busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b busy=%b data=%h expected 1/0/1/%h",
                         c, o_valid, o_ready, o_busy, o_data, pt);
            end
            tick();
        end
        i_ready = 1'b1;
        tick();
        sk_garbage = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: valid=%b busy=%b ready=%b expected 0/0/1",
                     o_valid, o_busy, o_ready);
        end
    endtask

    task automatic test_abort();
        logic [127:0] pt, got;
        int lat, n;
        key_schedule(rnd256());
        pt = rnd128();
        n  = 0;
        while (!o_ready && n < 100) begin
            tick();
            n++;
        end
        i_data  = encrypt(pt);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        n = 0;
        while (o_key_idx !== 6'd15 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (o_key_idx !== 6'd15 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_reach_r15: idx=%0d busy=%b expected 15/1", o_key_idx, o_busy);
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_data !== 128'h0 || o_ready !== 1'b0 ||
            o_key_idx !== 6'd32) begin
            failures++;
            $display("FAIL abort_outputs: valid=%b busy=%b ready=%b idx=%0d data=%h expected 0/0/0/32/0",
                     o_valid, o_busy, o_ready, o_key_idx, o_data);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        key_schedule(rnd256());
        pt = rnd128();
        send_and_wait(encrypt(pt), got, lat);
        checks++;
        if (got !== pt || lat !== 32) begin
            failures++;
            $display("FAIL abort_next_block: data=%h lat=%0d expected %h/32", got, lat, pt);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt [3];
        logic [127:0] ct [3];
        logic [127:0] res [3];
        int acc [3];
        int na, nr, n;
        bit acc_now, out_now;
        key_schedule(rnd256());
        for (int i = 0; i < 3; i++) begin
            pt[i] = rnd128();
            ct[i] = encrypt(pt[i]);
        end
        na = 0;
        nr = 0;
        n  = 0;
        i_ready = 1'b1;
        i_data  = ct[0];
        i_valid = 1'b1;
        while (nr < 3 && n < 300) begin
            acc_now = o_ready && i_valid;
            out_now = o_valid && i_ready;
            if (out_now) begin
                res[nr] = o_data;
                nr++;
            end
            if (acc_now) begin
                acc[na] = cyc;
                na++;
            end
            tick();
            n++;
            if (acc_now) begin
                if (na < 3) begin
                    i_data = ct[na];
                end else begin
                    i_valid = 1'b0;
                    i_data  = rnd128();
                end
            end
        end
        i_valid = 1'b0;
        checks++;
        if (nr !== 3 || na !== 3) begin
            failures++;
            $display("FAIL b2b_count: outputs=%0d accepts=%0d expected 3/3", nr, na);
        end
        for (int i = 0; i < nr; i++) begin
            checks++;
            if (res[i] !== pt[i]) begin
                failures++;
                $display("FAIL b2b_data[%0d]: got %h expected %h", i, res[i], pt[i]);
            end
        end
        for (int i = 1; i < na; i++) begin
            checks++;
            if (acc[i] - acc[i-1] !== 34) begin
                failures++;
                $display("FAIL b2b_spacing[%0d]: got %0d expected 34", i, acc[i] - acc[i-1]);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] pt, got;
        int lat;
        for (int i = 0; i < 100; i++) begin
            key_schedule(rnd256());
            pt = rnd128();
            send_and_wait(encrypt(pt), got, lat);
            checks++;
            if (got !== pt || lat !== 32) begin
                failures++;
                $display("FAIL random[%0d]: data=%h lat=%0d expected %h/32", i, got, lat, pt);
            end
        end
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_valid    = 1'b0;
        i_ready    = 1'b1;
        i_data     = '0;
        sk_garbage = 1'b0;
        key_schedule(256'h0);
        test_reset();
        test_kat();
        test_timing();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serpent_dec_core.md
SERPENT_DEC_CORE -- requirements
Module: serpent_dec_core

Interface
REQ-001 The block SHALL have one parameter: none; all widths are fixed (data 128 bits, round index 6 bits).
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port i_valid, input, 1 bit: ciphertext block offered.
REQ-005 The block SHALL have port o_ready, output, 1 bit: ready to accept a ciphertext.
REQ-006 The block SHALL have port i_data, input, 128 bits: ciphertext {X0,X1,X2,X3}, with X0 = [127:96] and X3 = [31:0].
REQ-007 The block SHALL have port o_key_idx, output, 6 bits: subkey index requested this cycle (0..32).
REQ-008 The block SHALL have port i_subkey, input, 128 bits: subkey K[o_key_idx], combinationally valid in the same cycle; same word layout as i_data.
REQ-009 The block SHALL have port o_valid, output, 1 bit: plaintext available.
REQ-010 The block SHALL have port i_ready, input, 1 bit: downstream accepts the plaintext.
REQ-011 The block SHALL have port o_data, output, 128 bits: plaintext, same layout as i_data.
REQ-012 The block SHALL have port o_busy, output, 1 bit: a block is in progress (RUN or DONE).

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-014 In IDLE, the block SHALL drive o_ready=1 and o_key_idx=32.
REQ-015 When i_valid&&o_ready, the block SHALL load state X <= i_data ^ i_subkey (K32), set round counter r <= 31, and go to RUN.
REQ-016 In RUN, the block SHALL drive o_ready=0 and o_key_idx=r.
REQ-017 In RUN, each cycle the block SHALL compute X <= InvS[r mod 8](Y) ^ i_subkey, where Y = X if r==31, else Y = LTinv(X).
REQ-018 LTinv SHALL be the team's Serpent inverse linear transform, bit-exact with the existing inverse-LT stage.
REQ-019 InvS[k] SHALL be the standard Serpent inverse S-box k, applied bitsliced: for each bit j in 0..31, nibble {X3[j],X2[j],X1[j],X0[j]} (X0 = LSB) is substituted and written back to the same bit positions.
REQ-020 In RUN, r SHALL decrement by 1 per cycle; the cycle processing r==0 SHALL move the FSM to DONE.
REQ-021 Latency SHALL be exactly 32 cycles: o_valid rises on the 32nd rising edge after the accepting edge.
REQ-022 In DONE, the block SHALL drive o_valid=1 and o_data=X, both held stable until i_ready==1.
REQ-023 In DONE with i_ready==1, the block SHALL return to IDLE on that edge.
REQ-024 The block SHALL NOT accept a new input in the same cycle as output handoff; o_ready rises one cycle later, giving a maximum throughput of one block per 34 cycles.
REQ-025 The block SHALL ignore i_valid while in RUN or DONE, and SHALL NOT sample i_data outside the accept edge.
REQ-026 i_subkey SHALL be sampled only in the accept cycle and in RUN cycles; in DONE its value SHALL have no effect.
REQ-027 o_busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-028 o_data SHALL be 0 whenever o_valid==0.

Reset
REQ-029 On i_rst_n==0, the block SHALL asynchronously enter IDLE with X=0, r=0, o_valid=0, o_data=0 and o_busy=0.
REQ-030 During reset, the block SHALL drive o_ready=0 and o_key_idx=32; o_ready SHALL rise in the first cycle after i_rst_n deasserts.
REQ-031 Reset asserted in RUN or DONE SHALL abort the block immediately with no o_valid pulse; the next accepted block SHALL decrypt correctly.

Verification
REQ-032 Known-answer test: key schedule from the 256-bit all-zero key, ciphertext produced by the team's encryption model for plaintext 0 -> o_data = 128'h0; additionally 100 random key/plaintext pairs SHALL match the model.
REQ-033 Timing test: accept at edge N -> o_valid=0 through edge N+31 and o_valid=1 after edge N+32; the bench SHALL observe the sequence o_key_idx = 32, 31, 30, ..., 0 on consecutive cycles.
REQ-034 Backpressure test: hold i_ready=0 for 10 cycles in DONE -> o_data stable and o_valid=1 throughout; i_ready=1 -> IDLE next cycle and o_ready=1 the cycle after.
REQ-035 Abort test: pulse i_rst_n low at round r=15 -> o_valid, o_busy and o_data=0 immediately; the next block SHALL decrypt correctly.
REQ-036 Back-to-back test: i_valid held high with 3 queued blocks -> 3 correct outputs with accept edges spaced 34 cycles apart, and no i_data sampled while busy.
